// File: rtl/sys_mem_arb_pkg.sv
// rtl/sys_mem_arb_pkg.sv - shared types, default sizing and round-robin select for sys_mem_arb
package sys_mem_arb_pkg;
  localparam int NUM_AGENTS_DEF     = 2;
  localparam int SYS_MEM_DATA_W_DEF = 32;
  localparam int SYS_MEM_ADDR_W_DEF = 27;
  localparam int MAX_OUTST_RD_DEF   = 8;
  localparam int AGT_IDX_W          = $clog2(NUM_AGENTS_DEF);

  typedef logic [AGT_IDX_W-1:0] agt_idx_t;
  typedef enum logic {IDLE, BUSY} arb_state_t;

  // First set bit of elig at or after ptr, wrapping mod n (n <= 32).
  function automatic int rr_select(input logic [31:0] elig, input int ptr, input int n);
    int idx;
    rr_select = ptr;
    for (int k = n - 1; k >= 0; k--) begin
      idx = (ptr + k) % n;
      if (elig[idx[4:0]]) rr_select = idx;
    end
  endfunction
endpackage

// File: rtl/sys_mem_arb_if.sv
// rtl/sys_mem_arb_if.sv - agent-side and controller-side bus bundle for sys_mem_arb
interface sys_mem_arb_if #(
  parameter int NUM_AGENTS     = 2,
  parameter int SYS_MEM_DATA_W = 32,
  parameter int SYS_MEM_ADDR_W = 27
);
  logic [NUM_AGENTS-1:0]                agt_wren;
  logic [NUM_AGENTS-1:0]                agt_rden;
  logic [NUM_AGENTS*SYS_MEM_ADDR_W-1:0] agt_addr;
  logic [NUM_AGENTS*SYS_MEM_DATA_W-1:0] agt_wdata;
  logic [NUM_AGENTS-1:0]                agt_wait;
  logic [NUM_AGENTS-1:0]                agt_rd_valid;
  logic [SYS_MEM_DATA_W-1:0]            agt_rdata;
  logic                                 mem_wait;
  logic                                 mem_wren;
  logic                                 mem_rden;
  logic [SYS_MEM_ADDR_W-1:0]            mem_addr;
  logic [SYS_MEM_DATA_W-1:0]            mem_wdata;
  logic                                 mem_rd_valid;
  logic [SYS_MEM_DATA_W-1:0]            mem_rdata;
  logic                                 rd_orphan_err;

  modport master (
    output agt_wren, agt_rden, agt_addr, agt_wdata, mem_wait, mem_rd_valid, mem_rdata,
    input  agt_wait, agt_rd_valid, agt_rdata, mem_wren, mem_rden, mem_addr, mem_wdata,
           rd_orphan_err
  );

  modport slave (
    input  agt_wren, agt_rden, agt_addr, agt_wdata, mem_wait, mem_rd_valid, mem_rdata,
    output agt_wait, agt_rd_valid, agt_rdata, mem_wren, mem_rden, mem_addr, mem_wdata,
           rd_orphan_err
  );
endinterface

// File: rtl/sys_mem_arb_tag_fifo.sv
// rtl/sys_mem_arb_tag_fifo.sv - synchronous FIFO of agent tags for in-flight reads
module sys_mem_arb_tag_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/sys_mem_arb.sv
// rtl/sys_mem_arb.sv - round-robin arbiter of N agents onto one system-memory port with in-order read return
module sys_mem_arb
  import sys_mem_arb_pkg::*;
#(
  parameter int NUM_AGENTS     = NUM_AGENTS_DEF,
  parameter int SYS_MEM_DATA_W = SYS_MEM_DATA_W_DEF,
  parameter int SYS_MEM_ADDR_W = SYS_MEM_ADDR_W_DEF,
  parameter int MAX_OUTST_RD   = MAX_OUTST_RD_DEF
) (
  input logic         clk,
  input logic         rst_n,
  sys_mem_arb_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_AGENTS);
  localparam int A_W   = SYS_MEM_ADDR_W;
  localparam int D_W   = SYS_MEM_DATA_W;

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      gnt_q, gnt_d, rr_q, rr_d, tag_head;
  logic [NUM_AGENTS-1:0] elig, wait_vec;
  logic                  req_wren, req_rden, accept, tag_push, tag_pop;
  logic                  tag_full, tag_empty, orphan_q;

  assign req_wren = bus.agt_wren[gnt_q];
  assign req_rden = bus.agt_rden[gnt_q];
  assign elig     = bus.agt_wren | (bus.agt_rden & {NUM_AGENTS{~tag_full}});
  assign accept   = (state_q == BUSY) && (req_wren || req_rden) && !bus.mem_wait;
  assign tag_push = accept && req_rden;
  assign tag_pop  = bus.mem_rd_valid && !tag_empty;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    wait_vec = '1;
    case (state_q)
      IDLE: begin
        if (|elig) begin
          gnt_d   = IDX_W'(rr_select(32'(elig), int'(rr_q), NUM_AGENTS));
          state_d = BUSY;
        end
      end
      BUSY: begin
        wait_vec[gnt_q] = bus.mem_wait;
        if (accept) begin
          state_d = IDLE;
          rr_d    = (gnt_q == IDX_W'(NUM_AGENTS - 1)) ? '0 : gnt_q + 1'b1;
        end else if (!req_wren && !req_rden) begin
          // Abandoned request: release the grant without advancing fairness.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_q     <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      if (bus.mem_rd_valid && tag_empty) orphan_q <= 1'b1;
    end
  end

  sys_mem_arb_tag_fifo #(
    .W     (IDX_W),
    .DEPTH (MAX_OUTST_RD)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (tag_push),
    .push_data (gnt_q),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  assign bus.mem_wren      = (state_q == BUSY) && req_wren;
  assign bus.mem_rden      = (state_q == BUSY) && req_rden;
  assign bus.mem_addr      = bus.agt_addr[gnt_q*A_W +: A_W];
  assign bus.mem_wdata     = bus.agt_wdata[gnt_q*D_W +: D_W];
  assign bus.agt_wait      = wait_vec;
  assign bus.agt_rd_valid  = tag_pop ? (NUM_AGENTS'(1) << tag_head) : '0;
  assign bus.agt_rdata     = bus.mem_rdata;
  assign bus.rd_orphan_err = orphan_q;
endmodule

// File: tb/tb_sys_mem_arb.sv
// tb/tb_sys_mem_arb.sv - self-checking bench for sys_mem_arb
module tb_sys_mem_arb;
  localparam int N = 2, A_W = 27, D_W = 32, DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sys_mem_arb_if #(.NUM_AGENTS(N), .SYS_MEM_DATA_W(D_W), .SYS_MEM_ADDR_W(A_W)) bus ();

  sys_mem_arb #(
    .NUM_AGENTS(N), .SYS_MEM_DATA_W(D_W), .SYS_MEM_ADDR_W(A_W), .MAX_OUTST_RD(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk)
    assert (!(|(bus.agt_wren & bus.agt_rden))) else $error("illegal wren+rden from an agent");

  int n_cmp = 0, n_mis = 0;

  // Reference model: current grant (-1 = none), fairness pointer, queue of read tags.
  int     m_gnt, m_rr;
  int     tagq[$];
  bit     m_err;
  logic [A_W-1:0] a_addr [N];
  logic [D_W-1:0] a_wdata[N];
  int     acc_idx;
  logic [N-1:0] s_wait, s_rdv;
  logic   s_wren, s_rden, s_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt = -1;
    m_rr  = 0;
    tagq.delete();
    m_err = 1'b0;
  endtask

  task automatic step(input logic rst, input logic [N-1:0] wr, input logic [N-1:0] rd,
                      input logic mw, input logic rv, input logic [D_W-1:0] rdat);
    logic [N-1:0] e_wait, e_rdv;
    logic e_wren, e_rden;
    int sz, ng, pv;
    bit do_push;
    @(negedge clk);
    rst_n = rst;
    bus.agt_wren = wr;
    bus.agt_rden = rd;
    bus.mem_wait = mw;
    bus.mem_rd_valid = rv;
    bus.mem_rdata = rdat;
    for (int i = 0; i < N; i++) begin
      bus.agt_addr[i*A_W +: A_W]  = a_addr[i];
      bus.agt_wdata[i*D_W +: D_W] = a_wdata[i];
    end
    #2;
    e_wait = '1; e_rdv = '0; e_wren = 1'b0; e_rden = 1'b0;
    if (m_gnt >= 0) begin
      e_wren = wr[m_gnt];
      e_rden = rd[m_gnt];
      e_wait[m_gnt] = mw;
    end
    if (rv && tagq.size() > 0) e_rdv[tagq[0]] = 1'b1;
    s_wait = bus.agt_wait; s_rdv = bus.agt_rd_valid;
    s_wren = bus.mem_wren; s_rden = bus.mem_rden; s_err = bus.rd_orphan_err;
    chk("agt_wait", 64'(s_wait), 64'(e_wait));
    chk("mem_wren", 64'(s_wren), 64'(e_wren));
    chk("mem_rden", 64'(s_rden), 64'(e_rden));
    chk("agt_rd_valid", 64'(s_rdv), 64'(e_rdv));
    chk("rd_orphan_err", 64'(s_err), 64'(m_err));
    if (m_gnt >= 0) begin
      chk("mem_addr", 64'(bus.mem_addr), 64'(a_addr[m_gnt]));
      chk("mem_wdata", 64'(bus.mem_wdata), 64'(a_wdata[m_gnt]));
    end
    if (e_rdv != '0) chk("agt_rdata", 64'(bus.agt_rdata), 64'(rdat));
    acc_idx = (m_gnt >= 0 && (e_wren || e_rden) && !mw) ? m_gnt : -1;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      sz = tagq.size(); ng = m_gnt; do_push = 1'b0; pv = 0;
      if (m_gnt < 0) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_rr + k) % N;
          if (ng < 0 && (wr[idx] || (rd[idx] && sz < DEPTH))) ng = idx;
        end
      end else if (acc_idx >= 0) begin
        if (rd[m_gnt]) begin do_push = 1'b1; pv = m_gnt; end
        m_rr = (m_gnt + 1) % N;
        ng = -1;
      end else if (!wr[m_gnt] && !rd[m_gnt]) begin
        ng = -1;
      end
      if (rv) begin
        if (sz > 0) void'(tagq.pop_front());
        else m_err = 1'b1;
      end
      if (do_push) tagq.push_back(pv);
      m_gnt = ng;
    end
  endtask

  typedef struct {
    logic rst; logic [1:0] wr, rd; logic mw, rv; logic [31:0] rdat;
    logic [1:0] e_wait; logic e_wren, e_rden; logic [1:0] e_rdv; logic e_err;
  } vec_t;
  vec_t tbl[13];

  initial begin
    int last, n_acc, n_acc0;
    bit got1;
    rst_n = 1'b0;
    bus.agt_wren = '0; bus.agt_rden = '0; bus.agt_addr = '0; bus.agt_wdata = '0;
    bus.mem_wait = 1'b0; bus.mem_rd_valid = 1'b0; bus.mem_rdata = '0;
    a_addr[0] = 27'h10; a_wdata[0] = 32'hdeadbabe;
    a_addr[1] = 27'h20; a_wdata[1] = 32'h11111111;
    repeat (2) @(posedge clk);
    model_reset();

    // rst, wr, rd, mw, rv, rdat, exp wait, wren, rden, rd_valid, err
    tbl[0]  = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,        2'b11, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[1]  = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0,        2'b11, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[2]  = '{1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 32'h0,        2'b10, 1'b1, 1'b0, 2'b00, 1'b0};
    tbl[3]  = '{1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0,        2'b11, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[4]  = '{1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 32'h0,        2'b01, 1'b0, 1'b1, 2'b00, 1'b0};
    tbl[5]  = '{1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 32'h0,        2'b11, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[6]  = '{1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 32'h0,        2'b10, 1'b0, 1'b1, 2'b00, 1'b0};
    tbl[7]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 32'hd1d1d1d1, 2'b11, 1'b0, 1'b0, 2'b10, 1'b0};
    tbl[8]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 32'hd2d2d2d2, 2'b11, 1'b0, 1'b0, 2'b01, 1'b0};
    tbl[9]  = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 32'h0,        2'b11, 1'b0, 1'b0, 2'b00, 1'b0};
    tbl[10] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,        2'b11, 1'b0, 1'b0, 2'b00, 1'b1};
    tbl[11] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,        2'b11, 1'b0, 1'b0, 2'b00, 1'b1};
    tbl[12] = '{1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,        2'b11, 1'b0, 1'b0, 2'b00, 1'b0};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].mw, tbl[i].rv, tbl[i].rdat);
      chk($sformatf("tbl%0d_wait", i), 64'(s_wait), 64'(tbl[i].e_wait));
      chk($sformatf("tbl%0d_wren", i), 64'(s_wren), 64'(tbl[i].e_wren));
      chk($sformatf("tbl%0d_rden", i), 64'(s_rden), 64'(tbl[i].e_rden));
      chk($sformatf("tbl%0d_rdv", i),  64'(s_rdv),  64'(tbl[i].e_rdv));
      chk($sformatf("tbl%0d_err", i),  64'(s_err),  64'(tbl[i].e_err));
      if (i == 2) chk("t1_wdata", 64'(bus.mem_wdata), 64'(32'hdeadbabe));
    end

    // Both agents writing continuously: grants must alternate.
    last = -1; n_acc = 0;
    for (int c = 0; c < 24; c++) begin
      step(1'b1, 2'b11, 2'b00, 1'b0, 1'b0, '0);
      if (acc_idx >= 0) begin
        if (last >= 0) chk("alt_grant", 64'(acc_idx), 64'(1 - last));
        last = acc_idx; n_acc++;
      end
    end
    chk("alt_count", 64'(n_acc), 64'(12));

    // Fill the tag FIFO, then reads stall while writes still pass.
    step(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, '0);
    n_acc = 0;
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 2'b00, 2'b11, 1'b0, 1'b0, '0);
      if (acc_idx >= 0) n_acc++;
    end
    chk("fill_reads", 64'(n_acc), 64'(DEPTH));
    n_acc0 = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 2'b01, 2'b10, 1'b0, 1'b0, '0);
      chk("full_rd_wait", 64'(s_wait[1]), 64'(1'b1));
      if (acc_idx == 0) n_acc0++;
    end
    chk("full_wr_accepts", 64'(n_acc0), 64'(3));
    step(1'b1, 2'b01, 2'b10, 1'b0, 1'b1, 32'h5a5a0001);
    got1 = 1'b0;
    for (int c = 0; c < 6 && !got1; c++) begin
      step(1'b1, 2'b01, 2'b10, 1'b0, 1'b0, '0);
      if (acc_idx == 1) got1 = 1'b1;
    end
    chk("read_after_pop", 64'(got1), 64'(1'b1));
    for (int c = 0; c < DEPTH; c++) step(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 32'(c));

    // Controller stall: grant and address hold, accept on the sixth busy cycle.
    step(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, '0);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 2'b01, 2'b00, 1'b1, 1'b0, '0);
      chk("stall_wren", 64'(s_wren), 64'(1'b1));
      chk("stall_addr", 64'(bus.mem_addr), 64'(27'h10));
    end
    step(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, '0);
    chk("stall_accept", 64'(acc_idx), 64'(0));

    // Reset with reads pending and a stalled grant, then a late return.
    for (int c = 0; c < 6; c++) step(1'b1, 2'b00, 2'b01, 1'b0, 1'b0, '0);
    step(1'b1, 2'b00, 2'b01, 1'b1, 1'b0, '0);
    step(1'b1, 2'b00, 2'b01, 1'b1, 1'b0, '0);
    step(1'b0, 2'b00, 2'b01, 1'b1, 1'b0, '0);
    step(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, '0);
    chk("rst_wait", 64'(s_wait), 64'(2'b11));
    chk("rst_rden", 64'(s_rden), 64'(1'b0));
    step(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 32'hbad0bad0);
    chk("late_rdv", 64'(s_rdv), 64'(2'b00));
    step(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, '0);
    chk("late_orphan", 64'(s_err), 64'(1'b1));

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] wr, rd;
      wr = '0; rd = '0;
      for (int i = 0; i < N; i++) begin
        case ($urandom % 4)
          1: wr[i] = 1'b1;
          2, 3: rd[i] = 1'b1;
          default: ;
        endcase
        a_addr[i]  = A_W'($urandom);
        a_wdata[i] = $urandom;
      end
      step(($urandom % 300) != 0, wr, rd, ($urandom % 4) == 0, ($urandom % 5) == 0, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
